// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS writeback result selector:
//   - load size encodings carried on in_ld_size
//   - writeback FSM state enum
//   - wait counter width and the DATA_W legality check
// -----------------------------------------------------------------------------
package mips_pkg;

  // Load size encodings (in_ld_size)
  localparam logic [1:0] LD_BYTE  = 2'b00;
  localparam logic [1:0] LD_HALF  = 2'b01;
  localparam logic [1:0] LD_WORD  = 2'b10;
  localparam logic [1:0] LD_DWORD = 2'b11;

  // Writeback FSM states
  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_e;

  // Wide enough for the largest legal TIMEOUT (255)
  localparam int WAIT_CNT_W = 8;

  // Only 32- and 64-bit datapaths are supported
  function automatic bit data_w_legal(input int w);
    return (w == 32) || (w == 64);
  endfunction

endpackage

// File: rtl/load_extend.sv
// -----------------------------------------------------------------------------
// load_extend
// Combinational lane select plus sign/zero extension for sub-word loads.
//   rdata_i  : raw data word returned by the data memory
//   size_i   : LD_BYTE / LD_HALF / LD_WORD / LD_DWORD
//   signed_i : 1 = sign-extend, 0 = zero-extend
//   offset_i : byte offset of the addressed lane within the data word
//   ext_o    : selected lane extended to DATA_W
// Alignment is checked upstream; this block assumes the lane fits the word.
// -----------------------------------------------------------------------------
module load_extend
  import mips_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        size_i,
  input  logic              signed_i,
  input  logic [OFF_W-1:0]  offset_i,
  output logic [DATA_W-1:0] ext_o
);

  localparam logic [DATA_W-1:0] MASK_B = DATA_W'(8'hFF);
  localparam logic [DATA_W-1:0] MASK_H = DATA_W'(16'hFFFF);
  localparam logic [DATA_W-1:0] MASK_W = DATA_W'(32'hFFFF_FFFF);
  localparam logic [DATA_W-1:0] MASK_D = {DATA_W{1'b1}};

  logic [DATA_W-1:0] lane;
  logic [DATA_W-1:0] mask;
  logic              msb;

  always_comb begin
    // Bring the addressed byte lane down to bit 0
    lane = rdata_i >> {offset_i, 3'b000};
    mask = MASK_D;
    msb  = lane[DATA_W-1];
    case (size_i)
      LD_BYTE: begin
        mask = MASK_B;
        msb  = lane[7];
      end
      LD_HALF: begin
        mask = MASK_H;
        msb  = lane[15];
      end
      LD_WORD: begin
        mask = MASK_W;
        msb  = lane[31];
      end
      default: begin
        mask = MASK_D;
        msb  = lane[DATA_W-1];
      end
    endcase
    // Keep the lane bits, fill everything above with the sign (or zeros)
    ext_o = (lane & mask) | ({DATA_W{signed_i & msb}} & ~mask);
  end

endmodule

// File: rtl/wb_result_select.sv
// -----------------------------------------------------------------------------
// wb_result_select
// Registered writeback result selector between the MEM stage and the
// register-file write port. ALU results are written one cycle after
// acceptance; loads wait for a variable-latency memory response, stalling
// upstream meanwhile, and are lane-aligned and extended before writeback.
//
// Ports
//   clk, rst       : clock, synchronous active-high reset
//   in_valid       : MEM-stage instruction present
//   in_reg_wen     : instruction writes a register
//   in_mem_en      : data memory access
//   in_mem_wen     : access is a store
//   in_rd          : destination register
//   in_alu_out     : ALU result
//   in_ld_size     : load size (byte/half/word/dword)
//   in_ld_signed   : sign-extend loaded value
//   in_byte_off    : byte offset of the load within the data word
//   mem_rdata      : load response data
//   mem_rvalid     : load response strobe
//   wb_wen         : one-cycle register-file write strobe
//   wb_rd, wb_data : write address / data, held while wb_wen=0
//   stall          : upstream must hold its inputs
//   err_timeout    : one-cycle pulse when a load is abandoned
//   err_align      : one-cycle pulse on a misaligned load
//
// Handshake: an instruction is accepted in a cycle where in_valid=1 and
// stall=0. While stall=1 the upstream holds its inputs and in_valid is
// ignored here; stall depends only on the FSM state, never on the inputs.
// -----------------------------------------------------------------------------
module wb_result_select
  import mips_pkg::*;
#(
  parameter  int DATA_W  = 32,
  parameter  int RADDR_W = 5,
  parameter  int TIMEOUT = 15,
  localparam int OFF_W   = $clog2(DATA_W / 8)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_reg_wen,
  input  logic               in_mem_en,
  input  logic               in_mem_wen,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0]  in_alu_out,
  input  logic [1:0]         in_ld_size,
  input  logic               in_ld_signed,
  input  logic [OFF_W-1:0]   in_byte_off,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               mem_rvalid,
  output logic               wb_wen,
  output logic [RADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0]  wb_data,
  output logic               stall,
  output logic               err_timeout,
  output logic               err_align
);

  // A build with an unsupported width never accepts instructions
  localparam bit CFG_OK = data_w_legal(DATA_W);
  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_C = WAIT_CNT_W'(TIMEOUT);

  // FSM and wait counter
  wb_state_e             state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  // Load context latched at acceptance
  logic [RADDR_W-1:0]    ld_rd_q, ld_rd_d;
  logic [1:0]            ld_size_q, ld_size_d;
  logic                  ld_signed_q, ld_signed_d;
  logic [OFF_W-1:0]      ld_off_q, ld_off_d;
  logic                  ld_wen_q, ld_wen_d;

  // Registered outputs
  logic                  wb_wen_q, wb_wen_d;
  logic [RADDR_W-1:0]    wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0]     wb_data_q, wb_data_d;
  logic                  err_timeout_q, err_timeout_d;
  logic                  err_align_q, err_align_d;

  // Instruction classification
  logic                  accept;
  logic                  is_alu;
  logic                  is_load;
  logic                  ld_misaligned;
  logic [DATA_W-1:0]     ld_ext;

  assign accept  = in_valid && CFG_OK;
  assign is_alu  = in_reg_wen && !in_mem_en;
  assign is_load = in_mem_en && !in_mem_wen;

  always_comb begin
    ld_misaligned = 1'b0;
    case (in_ld_size)
      LD_BYTE:  ld_misaligned = 1'b0;
      LD_HALF:  ld_misaligned = in_byte_off[0];
      LD_WORD:  ld_misaligned = |in_byte_off[1:0];
      // A dword on a 32-bit datapath cannot be satisfied; flag it as well
      default:  ld_misaligned = (|in_byte_off) || (DATA_W != 64);
    endcase
  end

  // Extraction always works on the latched context: upstream inputs may
  // already belong to the next instruction when the response arrives.
  load_extend #(
    .DATA_W (DATA_W)
  ) u_load_extend (
    .rdata_i  (mem_rdata),
    .size_i   (ld_size_q),
    .signed_i (ld_signed_q),
    .offset_i (ld_off_q),
    .ext_o    (ld_ext)
  );

  // Next-state and output logic
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ld_rd_d       = ld_rd_q;
    ld_size_d     = ld_size_q;
    ld_signed_d   = ld_signed_q;
    ld_off_d      = ld_off_q;
    ld_wen_d      = ld_wen_q;
    wb_wen_d      = 1'b0;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
    err_timeout_d = 1'b0;
    err_align_d   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          if (is_load) begin
            if (ld_misaligned) begin
              err_align_d = 1'b1;
            end else begin
              ld_rd_d     = in_rd;
              ld_size_d   = in_ld_size;
              ld_signed_d = in_ld_signed;
              ld_off_d    = in_byte_off;
              ld_wen_d    = in_reg_wen;
              // Counter holds the number of cycles spent in WAIT_MEM,
              // including the current one.
              cnt_d       = WAIT_CNT_W'(1);
              state_d     = WAIT_MEM;
            end
          end else if (is_alu) begin
            wb_wen_d  = 1'b1;
            wb_rd_d   = in_rd;
            wb_data_d = in_alu_out;
          end
        end
      end

      WAIT_MEM: begin
        if (mem_rvalid) begin
          // Response beats the timeout when both land in the same cycle
          if (ld_wen_q) begin
            wb_wen_d  = 1'b1;
            wb_rd_d   = ld_rd_q;
            wb_data_d = ld_ext;
          end
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q >= TIMEOUT_C) begin
          err_timeout_d = 1'b1;
          cnt_d         = '0;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + WAIT_CNT_W'(1);
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      ld_rd_q       <= '0;
      ld_size_q     <= LD_BYTE;
      ld_signed_q   <= 1'b0;
      ld_off_q      <= '0;
      ld_wen_q      <= 1'b0;
      wb_wen_q      <= 1'b0;
      wb_rd_q       <= '0;
      wb_data_q     <= '0;
      err_timeout_q <= 1'b0;
      err_align_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ld_rd_q       <= ld_rd_d;
      ld_size_q     <= ld_size_d;
      ld_signed_q   <= ld_signed_d;
      ld_off_q      <= ld_off_d;
      ld_wen_q      <= ld_wen_d;
      wb_wen_q      <= wb_wen_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
      err_timeout_q <= err_timeout_d;
      err_align_q   <= err_align_d;
    end
  end

  assign stall       = (state_q == WAIT_MEM);
  assign wb_wen      = wb_wen_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign err_timeout = err_timeout_q;
  assign err_align   = err_align_q;

endmodule
